mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-port arbiter and sequencer for the shared instruction/data memory bus.
- Port 0 is the CPU controller's fetch/operand/write-back path. Port 1 is the program loader / debug port.
- Grants the single memory bus to one requester at a time, round-robin on contention.
- Drives chip-select, read and write strobes for a fixed wait-state count, then returns read data with a one-cycle done pulse.

Parameters:
- AW, 8, address width of the memory bus.
- DW, 8, data width of the memory bus.
- WAIT_CYCLES, 1, extra cycles the strobes are held beyond the first access cycle (0..15).

Ports:
- clk1  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held high until done0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 owns the bus.
- done0  out  1  one-cycle completion pulse, port 0.
- req1  in  1  port 1 request.
- we1  in  1  port 1 write/read.
- addr1  in  AW  port 1 address.
- wdata1  in  DW  port 1 write data.
- gnt1  out  1  port 1 owns the bus.
- done1  out  1  completion pulse, port 1.
- rdata  out  DW  read data; valid while done0 or done1 is high.
- busy  out  1  high in ACCESS or DONE.
- mem_cs  out  1  memory chip select.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Clock and reset: one clock (clk1). Reset is asynchronous and active-low (rst).
- Reset values:
  - All outputs 0: gnt*, done*, rdata, busy, mem_cs, mem_rd, mem_wr, mem_addr, mem_wdata.
  - State = IDLE, wait counter = 0, last-grant pointer = 1, so port 0 wins the first tie.
- All outputs are registered.
- State IDLE:
  - If neither request is high, stay in IDLE with all strobes 0.
  - If only one request is high, that port wins.
  - If both are high, the winner is the port not granted last.
  - On the edge that grants: latch the winner's addr/wdata/we onto mem_addr/mem_wdata. Set mem_cs=1. Set mem_rd=~we, mem_wr=we. Set gnt=1 for the winner. Set busy=1. Load counter = WAIT_CYCLES. Update the pointer to the winner. Go to ACCESS.
- State ACCESS:
  - Strobes and address are held stable.
  - If counter≠0: decrement and stay.
  - If counter==0, on the next edge:
    - Capture mem_rdata into rdata (reads only; rdata unchanged on writes).
    - Pulse done of the granted port.
    - Drop mem_cs, mem_rd, mem_wr. Go to DONE.
- State DONE (one-cycle bus turnaround):
  - Clear done and gnt on the next edge. Clear busy. Go to IDLE.
- Latency, with request sampled at edge E0:
  - Strobes are high for exactly WAIT_CYCLES+1 cycles.
  - done is high for the cycle after edge E0+WAIT_CYCLES+1.
  - The next grant occurs no earlier than E0+WAIT_CYCLES+3.
- A requester dropping req mid-access does not abort; the access completes and done still pulses.
- The other port's req arriving during ACCESS/DONE is queued (not sampled) until IDLE.
- After done, a requester must drop req by the DONE cycle. A req still high when IDLE samples it is a new access.
- mem_rd and mem_wr are never high together.
- gnt0 and gnt1 are never high together.
- Reset mid-access: all strobes, gnt and done clear immediately (asynchronously). The pointer returns to 1. No done is issued for the aborted access.
- The counter is 4 bits. WAIT_CYCLES outside 0..15 is unsupported.

Test Plan:
- Single read, WAIT_CYCLES=1. req0=1, we0=0, addr0=8'h12, memory returns 8'hA5.
  Required: mem_cs/mem_rd high 2 cycles with mem_addr=8'h12; done0 pulses 1 cycle with rdata=8'hA5; gnt1 stays 0.
- Single write, port 1. req1=1, we1=1, addr1=8'h40, wdata1=8'h3C.
  Required: mem_wr high 2 cycles, mem_rd=0, mem_wdata=8'h3C; done1 pulses; rdata unchanged.
- Contention from reset. req0 and req1 rise together and stay high.
  Required: grants alternate 0,1,0,1. Each grant is separated by 4 cycles (WAIT_CYCLES=1); no cycle has both gnt high.
- Late request. req1 asserted during port 0's ACCESS.
  Required: port 0 completes; gnt1 rises at the edge after DONE.
- Reset mid-access. Assert rst low in the second ACCESS cycle.
  Required: mem_cs, mem_rd, gnt0 are 0 immediately; no done0. After release, a tie is won by port 0.
- WAIT_CYCLES=0 build. Single read.
  Required: strobes high 1 cycle; done0 pulses at E0+1.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared memory bus.
// Each grant runs IDLE -> ACCESS (WAIT_CYCLES+1 strobe cycles) -> DONE (turnaround) -> IDLE.
module mem_bus_arbiter #(
   parameter int AW          = 8,
   parameter int DW          = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk1,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          done0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          mem_cs,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ptr_q, ptr_d;          // last granted port: 1'b1 = port 1
   logic          gnt0_q, gnt0_d;
   logic          gnt1_q, gnt1_d;
   logic          done0_q, done0_d;
   logic          done1_q, done1_d;
   logic          busy_q, busy_d;
   logic          cs_q, cs_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          win1_s;
   logic          win_we_s;

   // State and output registers
   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         ptr_q   <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
         cs_q    <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= {AW{1'b0}};
         wdata_q <= {DW{1'b0}};
         rdata_q <= {DW{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
         cs_q    <= cs_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state, arbitration and strobe sequencing
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      gnt0_d   = gnt0_q;
      gnt1_d   = gnt1_q;
      done0_d  = done0_q;
      done1_d  = done1_q;
      busy_d   = busy_q;
      cs_d     = cs_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      // On a tie the port that was not granted last wins
      win1_s   = req1 & (~req0 | ~ptr_q);
      win_we_s = win1_s ? we1 : we0;

      case (state_q)
         ST_IDLE: begin
            if (req0 | req1) begin
               addr_d  = win1_s ? addr1 : addr0;
               wdata_d = win1_s ? wdata1 : wdata0;
               cs_d    = 1'b1;
               rd_d    = ~win_we_s;
               wr_d    = win_we_s;
               gnt0_d  = ~win1_s;
               gnt1_d  = win1_s;
               busy_d  = 1'b1;
               cnt_d   = WAIT_LD;
               ptr_d   = win1_s;
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (rd_q) begin
                  rdata_d = mem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
               done0_d = gnt0_q;
               done1_d = gnt1_q;
               cs_d    = 1'b0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done0_d = 1'b0;
            done1_d = 1'b0;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            done0_d = 1'b0;
            done1_d = 1'b0;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            busy_d  = 1'b0;
            cs_d    = 1'b0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign done0     = done0_q;
   assign done1     = done1_q;
   assign busy      = busy_q;
   assign mem_cs    = cs_q;
   assign mem_rd    = rd_q;
   assign mem_wr    = wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule
